// File: rtl/fetch_unit.sv
// fetch_unit: single-stage instruction fetch with an IF/ID pipeline register.
// A two-state machine (BOOT, RUN) holds the PC at RESET_PC for one cycle after
// reset release, then advances by 4 per cycle, honouring redirect and stall.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect target sends the PC to TRAP_VEC and pulses trap.
// When it is undefined, the target is word-aligned and trap/trap_addr are 0.
//
// state | meaning
// BOOT  | first cycle after reset release; PC held at RESET_PC, IF/ID idle
// RUN   | normal fetch: redirect > stall > advance
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        trap,
    output logic [31:0] trap_addr
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] if_pc_next;
    logic [31:0] if_instr_next;
    logic        if_valid_next;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_next;
    logic [31:0] trap_addr_next;
`else
    logic        unused_cfg;
    assign unused_cfg = ^{redirect_target[1:0], TRAP_VEC};
    assign trap       = 1'b0;
    assign trap_addr  = 32'h0000_0000;
`endif

    // Next-state and next-register computation; every field defaults to hold.
    always_comb begin
        state_next    = state;
        pc_next       = pc_out;
        if_pc_next    = if_id_pc;
        if_instr_next = if_id_instr;
        if_valid_next = if_id_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_next      = 1'b0;
        trap_addr_next = trap_addr;
`endif
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // Flush the wrong-path fetch; IF/ID payload is left as-is.
                    if_valid_next = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_target[1:0] != 2'b00) begin
                        pc_next        = TRAP_VEC;
                        trap_next      = 1'b1;
                        trap_addr_next = redirect_target;
                    end else begin
                        pc_next = redirect_target;
                    end
`else
                    pc_next = {redirect_target[31:2], 2'b00};
`endif
                end else if (!stall) begin
                    pc_next       = pc_out + 32'd4;
                    if_pc_next    = pc_out;
                    if_instr_next = instr_in;
                    if_valid_next = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= BOOT;
            pc_out      <= RESET_PC;
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= 32'h0000_0000;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc_out      <= pc_next;
            if_id_pc    <= if_pc_next;
            if_id_instr <= if_instr_next;
            if_id_valid <= if_valid_next;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Trap pulse and latched offending address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            trap      <= 1'b0;
            trap_addr <= 32'h0000_0000;
        end else begin
            trap      <= trap_next;
            trap_addr <= trap_addr_next;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit. Each step drives
// inputs on the falling edge, pushes the expected register state, and pops
// and compares it one time unit after the following rising edge.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        trap;
    logic [31:0] trap_addr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        chk_if;
        logic        trap;
        logic [31:0] taddr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_taddr;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_in        (instr_in),
        .pc_out          (pc_out),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid),
        .trap            (trap),
        .trap_addr       (trap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    // Combinational instruction memory.
    always_comb instr_in = mem(pc_out);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                        input logic [31:0] e_pc, input logic e_valid, input logic [31:0] e_ifpc,
                        input logic [31:0] e_instr, input logic chk_if, input logic e_trap,
                        input string tag);
        exp_t e;
        @(negedge clk);
        reset           = r;
        stall           = s;
        redirect        = rd;
        redirect_target = tgt;
        e.tag    = tag;
        e.pc     = e_pc;
        e.valid  = e_valid;
        e.ifpc   = e_ifpc;
        e.instr  = e_instr;
        e.chk_if = chk_if;
        e.trap   = e_trap;
        e.taddr  = exp_taddr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".pc"}, pc_out, e.pc);
            check({e.tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
            if (e.chk_if) begin
                check({e.tag, ".ifpc"}, if_id_pc, e.ifpc);
                check({e.tag, ".instr"}, if_id_instr, e.instr);
            end
            check({e.tag, ".trap"}, {31'd0, trap}, {31'd0, e.trap});
            check({e.tag, ".taddr"}, trap_addr, e.taddr);
        end
    endtask

    task automatic adv(input logic [31:0] e_pc, input logic [31:0] e_ifpc, input string tag);
        step(1'b1, 1'b0, 1'b0, 32'h0, e_pc, 1'b1, e_ifpc, mem(e_ifpc), 1'b1, 1'b0, tag);
    endtask

    initial begin
        reset           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        exp_taddr       = 32'h0;

        // Reset held two cycles, with stall/redirect asserted to show they lose.
        step(1'b0, 1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "rst0");
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "rst1");
        // BOOT cycle: stall/redirect ignored, IF/ID not loaded.
        step(1'b1, 1'b1, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "boot");
        adv(32'd4,  32'd0,  "adv4");
        adv(32'd8,  32'd4,  "adv8");
        adv(32'd12, 32'd8,  "adv12");
        adv(32'd16, 32'd12, "adv16");

        // Stall three cycles at pc 16.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 32'h0, 32'd16, 1'b1, 32'd12, mem(32'd12), 1'b1, 1'b0, "stall");
        adv(32'd20, 32'd16, "unstall");
        adv(32'd24, 32'd20, "adv24");
        adv(32'd28, 32'd24, "adv28");
        adv(32'd32, 32'd28, "adv32");
        adv(32'd36, 32'd32, "adv36");
        adv(32'd40, 32'd36, "adv40");
        adv(32'd44, 32'd40, "adv44");

        // Redirect wins over a simultaneous stall.
        step(1'b1, 1'b1, 1'b1, 32'd56, 32'd56, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "redir56");
        adv(32'd60, 32'd56, "tgt56");

        // Wrap at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "redir_top");
        adv(32'h0, 32'hFFFF_FFFC, "wrap");
        adv(32'h4, 32'h0,         "postwrap");

        // Misaligned redirect.
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_taddr = 32'h22;
        step(1'b1, 1'b0, 1'b1, 32'h22, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "misalign");
        adv(32'h44, 32'h40, "trapvec");
`else
        step(1'b1, 1'b0, 1'b1, 32'h22, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "misalign");
        adv(32'h24, 32'h20, "aligned_tgt");
`endif
        adv(32'h48 - 32'h20 * 32'(`ifdef FETCH_MISALIGN_TRAP_EN 0 `else 1 `endif),
            32'h44 - 32'h20 * 32'(`ifdef FETCH_MISALIGN_TRAP_EN 0 `else 1 `endif), "adv_after");

        // Reset together with redirect mid-stream.
        exp_taddr = 32'h0;
        step(1'b0, 1'b0, 1'b1, 32'h80, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "rst_mid");
        step(1'b1, 1'b1, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "boot2");
        adv(32'd4, 32'd0, "restart4");
        adv(32'd8, 32'd4, "restart8");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
